// File: rtl/ah_func_ci_driver_pkg.sv
// ============================================================================
// Module : ah_func_ci_driver_pkg
// Brief  : Shared constants and FSM state type for the CI accumulation driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ah_func_ci_driver_pkg;

  localparam logic [31:0] c_float_zero      = 32'h0000_0000;
  localparam int          c_default_latency = 66;
  localparam int          c_default_lane_w  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ah_func_ci_driver_if.sv
// ============================================================================
// Module : ah_func_ci_driver_if
// Brief  : Sample stream, function-unit operand bus and partial-sum stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ah_func_ci_driver_if
  import ah_func_ci_driver_pkg::*;
#(
  parameter int LANE_W = c_default_lane_w
);

  logic              x_valid;
  logic              x_ready;
  logic [31:0]       x_data;

  logic              ci_clk_en;
  logic [31:0]       ci_dataa;
  logic [31:0]       ci_datab;
  logic [31:0]       ci_result;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [LANE_W-1:0] out_lane;
  logic              out_last;

  modport master (
    input  x_valid, x_data, ci_result, out_ready,
    output x_ready, ci_clk_en, ci_dataa, ci_datab,
           out_valid, out_data, out_lane, out_last
  );

  modport slave (
    output x_valid, x_data, ci_result, out_ready,
    input  x_ready, ci_clk_en, ci_dataa, ci_datab,
           out_valid, out_data, out_lane, out_last
  );

endinterface

`default_nettype wire

// File: rtl/ah_func_lane_tracker.sv
// ============================================================================
// Module : ah_func_lane_tracker
// Brief  : Pipeline slot counter, warm-up counter and per-lane emitted bitmap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ah_func_lane_tracker
  import ah_func_ci_driver_pkg::*;
#(
  parameter int LATENCY = c_default_latency,
  parameter int LANE_W  = c_default_lane_w
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              retire,
  output logic [LANE_W-1:0] slot,
  output logic              warm,
  output logic              warm_ending,
  output logic              cur_emitted,
  output logic              last_pending
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [LANE_W-1:0] c_slot_max  = LANE_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  c_lat       = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0]  c_lat_m1    = CNT_W'(LATENCY - 1);

  logic [LANE_W-1:0]  r_slot;
  logic [CNT_W-1:0]   r_warm_cnt;
  logic [LATENCY-1:0] r_emitted;
  logic [CNT_W-1:0]   w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot     <= '0;
      r_warm_cnt <= '0;
      r_emitted  <= '0;
    end else if (clear) begin
      r_slot     <= '0;
      r_warm_cnt <= '0;
      r_emitted  <= '0;
    end else begin
      if (advance) begin
        r_slot <= (r_slot == c_slot_max) ? '0 : r_slot + 1'b1;
        if (r_warm_cnt != c_lat) begin
          r_warm_cnt <= r_warm_cnt + 1'b1;
        end
      end
      if (retire) begin
        r_emitted[r_slot] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_pop = w_pop + CNT_W'(r_emitted[i]);
    end
  end

  // warm_ending: the warm-up counter reaches LATENCY once this cycle's issue completes
  assign slot         = r_slot;
  assign warm         = (r_warm_cnt < c_lat);
  assign warm_ending  = (r_warm_cnt >= c_lat_m1);
  assign cur_emitted  = r_emitted[r_slot];
  assign last_pending = (w_pop == c_lat_m1);

endmodule

`default_nettype wire

// File: rtl/ah_func_ci_driver.sv
// ============================================================================
// Module : ah_func_ci_driver
// Brief  : Streams samples through a fixed-latency CI unit with interleaved sums.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ah_func_ci_driver
  import ah_func_ci_driver_pkg::*;
#(
  parameter int LATENCY = c_default_latency,
  parameter int LANE_W  = c_default_lane_w
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               n_samples,
  output logic                      busy,
  output logic                      done,
  ah_func_ci_driver_if.master       bus
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_n;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_done, w_done_nxt;

  logic        w_clear;
  logic        w_advance;
  logic        w_accept_x;
  logic        w_accept_out;

  logic [LANE_W-1:0] w_slot;
  logic        w_warm, w_warm_ending, w_cur_emitted, w_last_pending;

  logic        w_x_ready, w_clk_en, w_out_valid, w_out_last;
  logic [31:0] w_dataa, w_datab, w_out_data;
  logic [LANE_W-1:0] w_out_lane;

  ah_func_lane_tracker #(
    .LATENCY (LATENCY),
    .LANE_W  (LANE_W)
  ) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .clear        (w_clear),
    .advance      (w_advance),
    .retire       (w_accept_out),
    .slot         (w_slot),
    .warm         (w_warm),
    .warm_ending  (w_warm_ending),
    .cur_emitted  (w_cur_emitted),
    .last_pending (w_last_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_clear) begin
        r_n     <= n_samples;
        r_count <= '0;
      end else begin
        r_count <= w_count_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;
    w_clear      = 1'b0;
    w_accept_x   = 1'b0;
    w_accept_out = 1'b0;
    w_count_nxt  = r_count;
    w_x_ready    = 1'b0;
    w_clk_en     = 1'b0;
    w_dataa      = c_float_zero;
    w_datab      = c_float_zero;
    w_out_valid  = 1'b0;
    w_out_data   = c_float_zero;
    w_out_lane   = '0;
    w_out_last   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        w_clk_en    = 1'b1;
        w_x_ready   = (r_count < r_n);
        w_accept_x  = bus.x_valid & w_x_ready;
        // A +0.0 bubble leaves the lane's partial sum unchanged since f(0)=0
        w_dataa     = w_accept_x ? bus.x_data : c_float_zero;
        w_datab     = w_warm ? c_float_zero : bus.ci_result;
        w_count_nxt = r_count + 32'(w_accept_x);
        if ((w_count_nxt == r_n) && w_warm_ending) begin
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_clk_en     = 1'b1;
        w_out_valid  = ~w_cur_emitted;
        w_out_data   = bus.ci_result;
        w_out_lane   = w_slot;
        w_out_last   = w_out_valid & w_last_pending;
        w_accept_out = w_out_valid & bus.out_ready;
        // Unaccepted lanes recirculate and come back around LATENCY cycles later
        w_datab      = (w_cur_emitted | w_accept_out) ? c_float_zero : bus.ci_result;
        if (w_accept_out && w_last_pending) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_advance = (r_state != ST_IDLE);

  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign bus.x_ready   = w_x_ready;
  assign bus.ci_clk_en = w_clk_en;
  assign bus.ci_dataa  = w_dataa;
  assign bus.ci_datab  = w_datab;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_lane  = w_out_lane;
  assign bus.out_last  = w_out_last;

endmodule

`default_nettype wire

// File: tb/tb_ah_func_ci_driver.sv
// ============================================================================
// Module : tb_ah_func_ci_driver
// Brief  : Self-checking bench with an f(x)=x unit model and per-lane sum model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ah_func_ci_driver;
  import ah_func_ci_driver_pkg::*;

  localparam int LAT = 8;
  localparam int LW  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] n_samples = 32'd0;
  logic        busy, done;

  ah_func_ci_driver_if #(.LANE_W(LW)) bus();

  ah_func_ci_driver #(.LATENCY(LAT), .LANE_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_samples (n_samples),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Integer-valued, non-negative IEEE single conversions
  function automatic int f2i(input logic [31:0] b);
    int e;
    logic [31:0] m;
    if (b[30:0] == 31'd0) return 0;
    e = int'(b[30:23]) - 127;
    m = {8'd0, 1'b1, b[22:0]};
    if (e < 0) return 0;
    if (e >= 23) return int'(m << (e - 23));
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] m;
    logic [7:0]  ex;
    if (v <= 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    m  = 32'(v) << (23 - p);
    ex = 8'(p + 127);
    return {1'b0, ex, m[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Function unit: result = datab + dataa after LAT enabled clocks
  logic [31:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
  always @(posedge clk) begin
    if (bus.ci_clk_en) begin
      pipe[0] <= i2f(f2i(bus.ci_dataa) + f2i(bus.ci_datab));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.ci_result = pipe[LAT-1];

  // Job-level model state
  int          job_cyc = 100000;
  int          n_job = 0;
  int          acc_x = 0;
  int          lane_sum [LAT];
  bit          emitted [LAT];
  logic [31:0] got_val [LAT];
  int          n_emit = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          first_out = -1;
  int          last_lane = -1;
  bit          done_exp = 1'b0;

  int          xmode = 0;
  int          rmode = 0;
  logic [31:0] xdata_drv = 32'h0;

  // Stimulus driver: sole writer of the stream inputs
  initial begin
    bus.x_valid   = 1'b0;
    bus.x_data    = 32'h0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.x_data  = xdata_drv;
      bus.x_valid = (xmode == 0) || (job_cyc % 2 == 0);
      if (rmode == 0) bus.out_ready = 1'b1;
      else bus.out_ready = (job_cyc < LAT + 20) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle compare against the model
  initial begin
    int lane;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_clk_en",    32'(bus.ci_clk_en), 32'd0);
        chk("rst_x_ready",   32'(bus.x_ready),   32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_done",      32'(done),          32'd0);
        job_cyc  = 100000;
        done_exp = 1'b0;
      end else begin
        chk("clk_en", 32'(bus.ci_clk_en), 32'(busy));
        chk("done",   32'(done),          32'(done_exp));
        if (done) begin
          done_cnt++;
          done_cyc = job_cyc;
        end
        done_exp = 1'b0;
        chk("x_ready", 32'(bus.x_ready), 32'(busy && (acc_x < n_job)));
        if (!busy) chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
        if (busy && bus.x_valid && bus.x_ready) begin
          lane_sum[job_cyc % LAT] += f2i(bus.x_data);
          acc_x++;
        end
        if (bus.out_valid) begin
          lane = job_cyc % LAT;
          if (first_out < 0) first_out = job_cyc;
          chk("out_lane", 32'(bus.out_lane), 32'(lane));
          chk("no_dup",   32'(emitted[lane]), 32'd0);
          chk("out_data", bus.out_data, i2f(lane_sum[lane]));
          chk("out_last", 32'(bus.out_last), 32'(n_emit == LAT - 1));
          if (bus.out_ready) begin
            emitted[lane] = 1'b1;
            got_val[lane] = bus.out_data;
            n_emit++;
            if (bus.out_last) last_lane = lane;
            if (n_emit == LAT) done_exp = 1'b1;
          end
        end
        if (start && !busy) begin
          job_cyc = 0;
          n_job = int'(n_samples);
          acc_x = 0; n_emit = 0; done_cnt = 0;
          done_cyc = -1; first_out = -1; last_lane = -1;
          for (int i = 0; i < LAT; i++) begin
            lane_sum[i] = 0; emitted[i] = 1'b0; got_val[i] = 32'hdead_beef;
          end
        end else begin
          job_cyc++;
        end
      end
    end
  end

  task automatic run_job(input int n, input logic [31:0] xd, input int xm, input int rm);
    int cyc;
    xmode = xm; rmode = rm; xdata_drv = xd;
    @(posedge clk); #1;
    n_samples = 32'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 600) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 600) begin
      checks++;
      failures++;
      $display("FAIL job_timeout: actual=no done after %0d cycles required=done pulse", cyc);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("lanes_emitted", 32'(n_emit),   32'(LAT));
    chk("done_pulses",   32'(done_cnt), 32'd1);
    chk("samples_taken", 32'(acc_x),    32'(n));
  endtask

  initial begin
    int sum;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // N=20 of 1.0: lanes 0..3 collect three samples, lanes 4..7 two
    run_job(20, 32'h3f80_0000, 0, 0);
    for (int i = 0; i < LAT; i++)
      chk($sformatf("n20_lane%0d", i), got_val[i], (i < 4) ? 32'h4040_0000 : 32'h4000_0000);
    chk("n20_first_out", 32'(first_out), 32'd20);
    chk("n20_done_cyc",  32'(done_cyc),  32'd28);
    chk("n20_last_lane", 32'(last_lane), 32'd3);

    // Reset in the middle of a streaming run
    xmode = 0; rmode = 0; xdata_drv = 32'h3f80_0000;
    @(posedge clk); #1;
    n_samples = 32'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy",    32'(busy),          32'd0);
    chk("midrst_clk_en",  32'(bus.ci_clk_en), 32'd0);
    chk("midrst_x_ready", 32'(bus.x_ready),   32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Stale pipeline contents must not leak into the next job
    run_job(20, 32'h3f80_0000, 0, 0);
    for (int i = 0; i < LAT; i++)
      chk($sformatf("postrst_lane%0d", i), got_val[i], (i < 4) ? 32'h4040_0000 : 32'h4000_0000);

    // N=3 of 2.0: RUN still spans the full warm-up
    run_job(3, 32'h4000_0000, 0, 0);
    for (int i = 0; i < LAT; i++)
      chk($sformatf("n3_lane%0d", i), got_val[i], (i < 3) ? 32'h4000_0000 : 32'h0000_0000);
    chk("n3_first_out", 32'(first_out), 32'd8);
    chk("n3_done_cyc",  32'(done_cyc),  32'd16);

    // N=0: only bubbles, eight zero partial sums
    run_job(0, 32'h3f80_0000, 0, 0);
    for (int i = 0; i < LAT; i++)
      chk($sformatf("n0_lane%0d", i), got_val[i], 32'h0000_0000);
    chk("n0_done_cyc", 32'(done_cyc), 32'd16);

    // N=16 with x_valid toggling
    run_job(16, 32'h3f80_0000, 1, 0);
    sum = 0;
    for (int i = 0; i < LAT; i++) sum += f2i(got_val[i]);
    chk("n16_sum", 32'(sum), 32'd16);

    // N=8 with downstream stalled through early DRAIN, then random ready
    run_job(8, 32'h3f80_0000, 0, 1);
    for (int i = 0; i < LAT; i++)
      chk($sformatf("n8bp_lane%0d", i), got_val[i], 32'h3f80_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
